// File: rtl/spart_pkg.sv
// Shared definitions for the buffered SPART.
// Holds the host register addresses, the control and status bit positions,
// the TX/RX state encodings and the parity helper used by both directions.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA  = 2'b00;
  localparam logic [1:0] ADDR_CTRL  = 2'b01;
  localparam logic [1:0] ADDR_DIVLO = 2'b10;
  localparam logic [1:0] ADDR_DIVHI = 2'b11;

  // Control register bits
  localparam int CTRL_PEN   = 0;
  localparam int CTRL_ODD   = 1;
  localparam int CTRL_STOP2 = 2;

  // Status byte bits: {2'b00, ferr, perr, ovr, tx_idle, tbr, rda}
  localparam int ST_RDA    = 0;
  localparam int ST_TBR    = 1;
  localparam int ST_TXIDLE = 2;
  localparam int ST_OVR    = 3;
  localparam int ST_PERR   = 4;
  localparam int ST_FERR   = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP1,
    TX_STOP2
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Even parity of the byte, inverted for odd mode.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/spart_if.sv
// Host-side control interface of the buffered SPART.
// Ports (master = processor, slave = SPART):
//   iocs   chip select, one cycle per access
//   iorw   1 = read, 0 = write
//   ioaddr register select
//   rda    RX FIFO not empty
//   tbr    TX FIFO not full
// The 8-bit bidirectional data bus stays a plain inout on the SPART so the
// tristate resolution happens on an ordinary net.
interface spart_if;
  import spart_pkg::*;

  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);

endinterface

// File: rtl/spart_sync_fifo.sv
// Single-clock FIFO used for both SPART directions.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset (pointers/count only)
//   push_i      write wdata_i; ignored when full unless a pop happens too
//   pop_i       advance the read pointer; ignored when empty
//   wdata_i     data to store
//   rdata_o     head entry (undefined content when empty)
//   full_o      count == DEPTH
//   empty_o     count == 0
//   count_o     number of stored entries
module spart_sync_fifo
  import spart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

  // A pop frees the slot this same edge, so a full FIFO may accept a push
  // alongside it.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= wdata_i;
  end

  assign rdata_o = mem[rd_q];

endmodule

// File: rtl/spart_buffered.sv
// Buffered SPART: host register bus in front of a TX FIFO and an RX FIFO,
// a programmable baud tick generator, a transmit FSM and a receive FSM.
// Ports:
//   clk      system clock (rising edge)
//   rst      asynchronous active-low reset
//   bus      host control signals (iocs/iorw/ioaddr in, rda/tbr out)
//   databus  8-bit host data, driven only while iocs && iorw
//   txd      serial output, idles high
//   rxd      serial input, asynchronous to clk
module spart_buffered
  import spart_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 8,
  parameter int          OVERSAMPLE    = 16,
  parameter logic [15:0] RESET_DIVISOR = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  spart_if.slave     bus,
  inout  wire  [7:0] databus,
  output logic       txd,
  input  logic       rxd
);

  localparam int             AW        = $clog2(FIFO_DEPTH);
  localparam int             OSW       = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_MID    = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

  // ---------------------------------------------------------------- host bus
  logic       wr_en, rd_en;
  logic [7:0] wdata, rdata, status;

  assign wr_en   = bus.iocs & ~bus.iorw;
  assign rd_en   = bus.iocs & bus.iorw;
  assign wdata   = databus;
  assign databus = rd_en ? rdata : 8'hzz;

  logic [2:0]  ctrl_q;
  logic [15:0] div_q;
  logic        div_wr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      div_q    <= RESET_DIVISOR;
      div_wr_q <= 1'b0;
    end else begin
      div_wr_q <= wr_en & ((bus.ioaddr == ADDR_DIVLO) | (bus.ioaddr == ADDR_DIVHI));
      if (wr_en) begin
        case (bus.ioaddr)
          ADDR_CTRL:  ctrl_q      <= wdata[2:0];
          ADDR_DIVLO: div_q[7:0]  <= wdata;
          ADDR_DIVHI: div_q[15:8] <= wdata;
          default:    ;
        endcase
      end
    end
  end

  // ------------------------------------------------------------ baud ticks
  // Counting divisor-1 .. 0 gives exactly one tick every div_q cycles.
  logic [15:0] bcnt_q;
  logic        run, tick;

  assign run  = (div_q != 16'd0);
  assign tick = run & ~div_wr_q & (bcnt_q == 16'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  bcnt_q <= RESET_DIVISOR - 16'd1;
    else if (div_wr_q || (bcnt_q == 16'd0))    bcnt_q <= div_q - 16'd1;
    else                                       bcnt_q <= bcnt_q - 16'd1;
  end

  // ----------------------------------------------------------------- FIFOs
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    tx_rdata, rx_rdata, rx_wdata;
  logic [AW:0]   tx_count, rx_count;
  logic          rda_w, tbr_w;

  assign tx_push = wr_en & (bus.ioaddr == ADDR_DATA) & ~tx_full;
  assign rx_pop  = rd_en & (bus.ioaddr == ADDR_DATA) & ~rx_empty;

  spart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (wdata),
    .rdata_o (tx_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  spart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_wdata),
    .rdata_o (rx_rdata),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign rda_w   = (rx_count != '0);
  assign tbr_w   = (tx_count != FIFO_FULL);
  assign bus.rda = rda_w;
  assign bus.tbr = tbr_w;

  // ---------------------------------------------------------------- TX FSM
  tx_state_t      tx_state_q, tx_state_d;
  logic           tx_wait_q, tx_wait_d;   // frame loaded, start bit not yet opened by a tick
  logic [OSW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]     tx_bit_q, tx_bit_d;
  logic [2:0]     tx_cfg_q, tx_cfg_d;     // settings frozen for the frame in flight
  logic [7:0]     tx_sh_q, tx_sh_d;
  logic           tx_par_q, tx_par_d;
  logic           txd_q, txd_d;
  logic           tx_bit_end, tx_load, tx_finish;

  assign tx_bit_end = tick & ~tx_wait_q & (tx_cnt_q == OS_LAST);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_wait_d  = tx_wait_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_cfg_d   = tx_cfg_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    tx_finish  = 1'b0;
    txd_d      = 1'b1;

    if (tick && !tx_wait_q && (tx_state_q != TX_IDLE))
      tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;

    case (tx_state_q)
      TX_IDLE: begin
        if (run && !tx_empty) begin
          tx_load   = 1'b1;
          tx_wait_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_wait_q) begin
          if (tick) tx_wait_d = 1'b0;
        end else if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          if (tx_bit_q == 3'd7)
            tx_state_d = tx_cfg_q[CTRL_PEN] ? TX_PARITY : TX_STOP1;
          else
            tx_bit_d = tx_bit_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) tx_state_d = TX_STOP1;
      end
      TX_STOP1: begin
        if (tx_bit_end) begin
          if (tx_cfg_q[CTRL_STOP2]) tx_state_d = TX_STOP2;
          else                      tx_finish  = 1'b1;
        end
      end
      TX_STOP2: begin
        if (tx_bit_end) tx_finish = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // A queued byte starts its start bit on the very tick that ends the
    // previous stop bit, so consecutive frames abut.
    if (tx_finish) begin
      if (!tx_empty) begin
        tx_load   = 1'b1;
        tx_wait_d = 1'b0;
      end else begin
        tx_state_d = TX_IDLE;
      end
    end

    if (tx_load) begin
      tx_pop     = 1'b1;
      tx_sh_d    = tx_rdata;
      tx_par_d   = parity_bit(tx_rdata, ctrl_q[CTRL_ODD]);
      tx_cfg_d   = ctrl_q;
      tx_state_d = TX_START;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
    end

    case (tx_state_d)
      TX_START:  txd_d = tx_wait_d;
      TX_DATA:   txd_d = tx_sh_d[tx_bit_d];
      TX_PARITY: txd_d = tx_par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_wait_q  <= 1'b0;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_cfg_q   <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_wait_q  <= tx_wait_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_cfg_q   <= tx_cfg_d;
      txd_q      <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh_q  <= tx_sh_d;
    tx_par_q <= tx_par_d;
  end

  assign txd = txd_q;

  // ---------------------------------------------------------------- RX FSM
  logic           rxd_s1_q, rxd_s2_q, rxd_prev_q;
  rx_state_t      rx_state_q, rx_state_d;
  logic [OSW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic           rx_pen_q, rx_pen_d;
  logic           rx_odd_q, rx_odd_d;
  logic           rx_perr_q, rx_perr_d;   // parity mismatch held until the push
  logic [7:0]     rx_sh_q, rx_sh_d;
  logic           rx_smp;
  logic           set_ferr, set_perr, set_ovr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  // Start bit is sampled at mid-bit; every later bit one full bit period on.
  assign rx_smp = tick & ((rx_state_q == RX_START) ? (rx_cnt_q == OS_MID)
                                                    : (rx_cnt_q == OS_LAST));
  assign rx_wdata = rx_sh_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_pen_d   = rx_pen_q;
    rx_odd_d   = rx_odd_q;
    rx_perr_d  = rx_perr_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    set_ferr   = 1'b0;
    set_perr   = 1'b0;
    set_ovr    = 1'b0;

    if (tick && (rx_state_q != RX_IDLE))
      rx_cnt_d = rx_smp ? '0 : rx_cnt_q + 1'b1;

    case (rx_state_q)
      RX_IDLE: begin
        if (run && rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
          rx_pen_d   = ctrl_q[CTRL_PEN];
          rx_odd_d   = ctrl_q[CTRL_ODD];
          rx_perr_d  = 1'b0;
        end
      end
      RX_START: begin
        if (rx_smp) begin
          if (rxd_s2_q) rx_state_d = RX_IDLE;
          else begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end
        end
      end
      RX_DATA: begin
        if (rx_smp) begin
          rx_sh_d = {rxd_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = rx_pen_q ? RX_PARITY : RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_smp) begin
          rx_perr_d  = (rxd_s2_q != parity_bit(rx_sh_q, rx_odd_q));
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_smp) begin
          set_ferr   = ~rxd_s2_q;
          set_perr   = rx_perr_q;
          set_ovr    = rx_full;
          rx_push    = ~rx_full;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_pen_q   <= 1'b0;
      rx_odd_q   <= 1'b0;
      rx_perr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_pen_q   <= rx_pen_d;
      rx_odd_q   <= rx_odd_d;
      rx_perr_q  <= rx_perr_d;
    end
  end

  always_ff @(posedge clk) begin
    rx_sh_q <= rx_sh_d;
  end

  // ------------------------------------------------------ flags and status
  logic ferr_q, perr_q, ovr_q, stat_rd;

  assign stat_rd = rd_en & (bus.ioaddr == ADDR_CTRL);

  // Sticky; a set landing on the clearing read survives it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= set_ferr | (ferr_q & ~stat_rd);
      perr_q <= set_perr | (perr_q & ~stat_rd);
      ovr_q  <= set_ovr  | (ovr_q  & ~stat_rd);
    end
  end

  always_comb begin
    status            = 8'h00;
    status[ST_RDA]    = rda_w;
    status[ST_TBR]    = tbr_w;
    status[ST_TXIDLE] = tx_empty & (tx_state_q == TX_IDLE);
    status[ST_OVR]    = ovr_q;
    status[ST_PERR]   = perr_q;
    status[ST_FERR]   = ferr_q;
  end

  always_comb begin
    rdata = 8'h00;
    case (bus.ioaddr)
      ADDR_DATA:  rdata = rx_empty ? 8'h00 : rx_rdata;
      ADDR_CTRL:  rdata = status;
      ADDR_DIVLO: rdata = div_q[7:0];
      ADDR_DIVHI: rdata = div_q[15:8];
      default:    rdata = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_spart_buffered.sv
// Directed bench for spart_buffered: register access, TX framing and FIFO
// fill, loopback receive, RX error flags, overrun, glitch rejection and
// asynchronous reset. Divisor 4 with OVERSAMPLE 16 makes a bit 64 cycles.
module tb_spart_buffered;
  import spart_pkg::*;

  localparam int BIT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       drv_en;
  logic [7:0] drv_data;
  logic       rxd_drv;
  logic       loop_en;
  wire  [7:0] databus;
  logic       txd;
  logic       rxd;

  int n_total = 0;
  int n_pass  = 0;

  spart_if bus_if ();

  assign databus = drv_en ? drv_data : 8'hzz;
  assign rxd     = loop_en ? txd : rxd_drv;

  spart_buffered #(
    .FIFO_DEPTH    (8),
    .OVERSAMPLE    (16),
    .RESET_DIVISOR (16'd325)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if),
    .databus (databus),
    .txd     (txd),
    .rxd     (rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.iocs   = 1'b1;
    bus_if.iorw   = 1'b0;
    bus_if.ioaddr = a;
    drv_data      = d;
    drv_en        = 1'b1;
    @(negedge clk);
    bus_if.iocs = 1'b0;
    drv_en      = 1'b0;
  endtask

  task automatic host_rd(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_if.iocs   = 1'b1;
    bus_if.iorw   = 1'b1;
    bus_if.ioaddr = a;
    #1 d = databus;
    @(negedge clk);
    bus_if.iocs = 1'b0;
  endtask

  task automatic wait_txd_low(input string tag, input int maxc);
    int n = 0;
    while (txd !== 1'b0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {15'd0, (txd === 1'b0)}, 16'd1);
  endtask

  task automatic wait_rda(input string tag, input int maxc);
    int n = 0;
    while (bus_if.rda !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {15'd0, (bus_if.rda === 1'b1)}, 16'd1);
  endtask

  // Drive nb serial bits onto rxd, LSB of bits first, one bit period each.
  task automatic send_rx(input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      rxd_drv = bits[i];
      repeat (BIT - 1) @(negedge clk);
    end
    @(negedge clk);
    rxd_drv = 1'b1;
  endtask

  initial begin
    logic [7:0] rd;
    logic [9:0] frm;
    int         len;

    rst           = 1'b0;
    drv_en        = 1'b0;
    drv_data      = 8'h00;
    rxd_drv       = 1'b1;
    loop_en       = 1'b0;
    bus_if.iocs   = 1'b0;
    bus_if.iorw   = 1'b0;
    bus_if.ioaddr = 2'b00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", {15'd0, txd}, 16'd1);
    check("rst_rda", {15'd0, bus_if.rda}, 16'd0);
    check("rst_tbr", {15'd0, bus_if.tbr}, 16'd1);
    rst = 1'b1;
    host_rd(ADDR_CTRL, rd);  check("rst_status", {8'd0, rd}, 16'h0006);
    host_rd(ADDR_DIVLO, rd); check("rst_divlo", {8'd0, rd}, 16'h0045);
    host_rd(ADDR_DIVHI, rd); check("rst_divhi", {8'd0, rd}, 16'h0001);
    host_rd(ADDR_DATA, rd);  check("empty_read", {8'd0, rd}, 16'h0000);

    // Basic TX of 8'hA5 at divisor 4
    host_wr(ADDR_DIVLO, 8'd4);
    host_wr(ADDR_DIVHI, 8'd0);
    host_rd(ADDR_DIVLO, rd); check("divlo_rb", {8'd0, rd}, 16'h0004);
    host_wr(ADDR_DATA, 8'hA5);
    wait_txd_low("tx_start_seen", 400);
    len = 0;
    while (txd === 1'b0 && len < 200) begin
      @(negedge clk);
      len++;
    end
    check("tx_start_len", 16'(len), 16'd64);
    repeat (BIT / 2 - 1) @(negedge clk);
    frm = 10'd0;
    for (int b = 1; b < 10; b++) begin
      frm[b] = txd;
      if (b < 9) repeat (BIT) @(negedge clk);
    end
    check("tx_a5_bits", {6'd0, frm}, {6'd0, 1'b1, 8'hA5, 1'b0});
    repeat (40) @(negedge clk);
    host_rd(ADDR_CTRL, rd); check("tx_idle_after", {8'd0, rd}, 16'h0006);

    // TX FIFO fill with the baud generator stopped
    host_wr(ADDR_DIVLO, 8'd0);
    for (int i = 0; i < 9; i++) begin
      host_wr(ADDR_DATA, 8'h10 + 8'(i));
      if (i == 6) check("tbr_after7", {15'd0, bus_if.tbr}, 16'd1);
      if (i == 7) check("tbr_after8", {15'd0, bus_if.tbr}, 16'd0);
    end
    host_rd(ADDR_CTRL, rd); check("full_status", {8'd0, rd}, 16'h0000);
    host_wr(ADDR_DIVLO, 8'd4);
    wait_txd_low("fill_start_seen", 400);
    repeat (BIT / 2) @(negedge clk);
    for (int f = 0; f < 8; f++) begin
      for (int b = 0; b < 10; b++) begin
        frm[b] = txd;
        repeat (BIT) @(negedge clk);
      end
      check($sformatf("fill_frame%0d", f), {6'd0, frm}, {6'd0, 1'b1, 8'h10 + 8'(f), 1'b0});
    end
    check("ninth_lost", {15'd0, txd}, 16'd1);
    repeat (BIT) @(negedge clk);
    host_rd(ADDR_CTRL, rd); check("fill_idle", {8'd0, rd}, 16'h0006);

    // Loopback with odd parity
    loop_en = 1'b1;
    host_wr(ADDR_CTRL, 8'h03);
    host_wr(ADDR_DATA, 8'h3C);
    wait_rda("loop_rda", 1500);
    host_rd(ADDR_DATA, rd); check("loop_data", {8'd0, rd}, 16'h003C);
    check("loop_rda_clr", {15'd0, bus_if.rda}, 16'd0);
    repeat (80) @(negedge clk);
    host_rd(ADDR_CTRL, rd); check("loop_status", {8'd0, rd}, 16'h0006);
    loop_en = 1'b0;

    // Byte 0x81 with parity 0 (odd mode wants 1) and stop bit low
    send_rx(16'h0102, 11);
    repeat (10) @(negedge clk);
    host_rd(ADDR_CTRL, rd); check("err_status", {8'd0, rd}, 16'h0037);
    host_rd(ADDR_CTRL, rd); check("err_cleared", {8'd0, rd}, 16'h0007);
    host_rd(ADDR_DATA, rd); check("err_data", {8'd0, rd}, 16'h0081);

    // Overrun: nine 8N1 frames without reading
    host_wr(ADDR_CTRL, 8'h00);
    for (int i = 0; i < 9; i++)
      send_rx({6'd0, 1'b1, 8'h40 + 8'(i), 1'b0}, 10);
    repeat (10) @(negedge clk);
    host_rd(ADDR_CTRL, rd); check("ovr_status", {8'd0, rd}, 16'h000F);
    for (int i = 0; i < 8; i++) begin
      host_rd(ADDR_DATA, rd);
      check($sformatf("ovr_data%0d", i), {8'd0, rd}, {8'd0, 8'h40 + 8'(i)});
    end
    check("ovr_drained", {15'd0, bus_if.rda}, 16'd0);
    host_rd(ADDR_CTRL, rd); check("ovr_cleared", {8'd0, rd}, 16'h0006);

    // Short glitch on rxd is a false start
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (4) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (100) @(negedge clk);
    host_rd(ADDR_CTRL, rd); check("glitch_status", {8'd0, rd}, 16'h0006);

    // Asynchronous reset in the middle of a TX frame with RX data pending
    send_rx({6'd0, 1'b1, 8'h5A, 1'b0}, 10);
    repeat (10) @(negedge clk);
    check("pre_rst_rda", {15'd0, bus_if.rda}, 16'd1);
    host_wr(ADDR_DATA, 8'hC3);
    wait_txd_low("rst_tx_start", 400);
    repeat (10) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_txd", {15'd0, txd}, 16'd1);
    check("async_rda", {15'd0, bus_if.rda}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    host_rd(ADDR_DIVLO, rd); check("post_rst_divlo", {8'd0, rd}, 16'h0045);
    host_rd(ADDR_CTRL, rd);  check("post_rst_status", {8'd0, rd}, 16'h0006);
    repeat (100) @(negedge clk);
    check("post_rst_txd", {15'd0, txd}, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
